rotate_right_iterative: RTL

Multi-cycle runtime-amount right rotator with valid/ready handshakes on both sides. It captures a data word and a rotation amount, rotates by STEP positions per cycle (single positions for the remainder), then holds the result until the consumer accepts it. It sits downstream of the request source and reuses the static rotate_right block as its per-cycle datapath, giving an area-cheap alternative to a full barrel rotator.

---
 rtl/rotate_right_iterative_pkg.sv | 8 +
 rtl/rotate_right.sv | 10 +
 rtl/rotate_right_iterative.sv | 74 +++++++
 3 files changed

// File: rtl/rotate_right_iterative_pkg.sv
// rotate_right_iterative_pkg: shared state encoding for the iterative right rotator.
package rotate_right_iterative_pkg;
    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;
endpackage

// File: rtl/rotate_right.sv
// rotate_right: static right rotation of a word by a fixed ROTATION positions.
module rotate_right #(
    parameter int WIDTH    = 8,
    parameter int ROTATION = 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result
);
    assign result = (data >> ROTATION) | (data << (WIDTH - ROTATION));
endmodule

// File: rtl/rotate_right_iterative.sv
// rotate_right_iterative: multi-cycle right rotator, STEP positions per cycle then single steps.
// Define ROTATE_RIGHT_ITERATIVE_EARLY_ACCEPT_EN to accept a new request in the output handshake cycle.
module rotate_right_iterative
    import rotate_right_iterative_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2,
    localparam int AMOUNT_WIDTH = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WIDTH-1:0]        input_data,
    input  logic [AMOUNT_WIDTH-1:0] input_amount,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH-1:0]        output_data
);
    state_t                  state, state_n;
    logic [WIDTH-1:0]        data_q, data_n, rot_step, rot_one;
    logic [AMOUNT_WIDTH-1:0] remaining, remaining_n, amount_mod;
    logic [AMOUNT_WIDTH:0]   amount_ext;
    logic                    accept, coarse;

    rotate_right #(.WIDTH(WIDTH), .ROTATION(STEP)) u_rot_step (.data(data_q), .result(rot_step));
    rotate_right #(.WIDTH(WIDTH), .ROTATION(1))    u_rot_one  (.data(data_q), .result(rot_one));

`ifdef ROTATE_RIGHT_ITERATIVE_EARLY_ACCEPT_EN
    assign input_ready = (state == IDLE) | ((state == DONE) & output_ready);
`else
    assign input_ready = (state == IDLE);
`endif

    // One conditional subtract suffices: the amount field is always below 2*WIDTH.
    assign amount_ext   = {1'b0, input_amount};
    assign amount_mod   = (amount_ext >= (AMOUNT_WIDTH+1)'(WIDTH))
                        ? AMOUNT_WIDTH'(amount_ext - (AMOUNT_WIDTH+1)'(WIDTH)) : input_amount;
    assign accept       = input_valid & input_ready;
    assign coarse       = remaining >= AMOUNT_WIDTH'(STEP);
    assign output_valid = (state == DONE);
    assign output_data  = data_q;

    always_comb begin
        state_n     = state;
        data_n      = data_q;
        remaining_n = remaining;
        if (state == ROTATE) begin
            data_n      = coarse ? rot_step : rot_one;
            remaining_n = remaining - (coarse ? AMOUNT_WIDTH'(STEP) : AMOUNT_WIDTH'(1));
            state_n     = (remaining_n == '0) ? DONE : ROTATE;
        end else begin
            if (state == DONE && output_ready)
                state_n = IDLE;
            if (accept) begin
                data_n      = input_data;
                remaining_n = amount_mod;
                state_n     = (amount_mod != '0) ? ROTATE : DONE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_q    <= '0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            data_q    <= data_n;
            remaining <= remaining_n;
        end
    end
endmodule
